// File: rtl/rx_frame_filter.sv
// Store-and-forward 8-bit receive filter: drops bad, runt, giant and overflowed frames and tags
// forwarded frames with their length. Define RX_FRAME_FILTER_STATS_EN to build the per-cause counters.
module rx_frame_filter #(
  parameter int DEPTH_LOG2   = 11,
  parameter int LENQ_LOG2    = 2,
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518,
  parameter int C_USER_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tstrb,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_err,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [C_USER_WIDTH-1:0] m_axis_tuser,
  output logic [31:0]             stat_good,
  output logic [31:0]             stat_drop_err,
  output logic [31:0]             stat_drop_len,
  output logic [31:0]             stat_drop_ovf
);

  localparam logic [DEPTH_LOG2:0] BUF_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [LENQ_LOG2:0]  LQ_DEPTH  = {1'b1, {LENQ_LOG2{1'b0}}};
  localparam logic [LENQ_LOG2:0]  LQ_ONE    = {{LENQ_LOG2{1'b0}}, 1'b1};
  localparam logic [16:0]         MIN_L     = 17'(MIN_LEN);
  localparam logic [16:0]         MAX_L     = 17'(MAX_LEN);
  localparam logic [0:0]          S_IDLE    = 1'b0;
  localparam logic [0:0]          S_SEND    = 1'b1;

  logic [7:0]          r_mem    [2**DEPTH_LOG2];
  logic [15:0]         r_lq_mem [2**LENQ_LOG2];
  logic [DEPTH_LOG2:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  logic [LENQ_LOG2:0]  r_lq_wr, r_lq_rd;
  logic [15:0]         r_wcnt, r_rcnt, r_tuser_len;
  logic                r_ovf, r_tvalid;
  logic [0:0]          r_state;
  logic [7:0]          r_tdata;

  logic                  w_accept, w_full, w_wr_en, w_eof, w_lq_full, w_lq_empty;
  logic                  w_drop_ovf, w_drop_err, w_drop_len, w_commit;
  logic                  w_hs, w_last_hs, w_fetch, w_unused_tstrb;
  logic [16:0]           w_len;
  logic [DEPTH_LOG2:0]   w_wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [15:0]           w_head;

  assign w_unused_tstrb = s_axis_tstrb;

  // The input side never back-pressures; congestion turns into frame drops instead.
  assign s_axis_tready = !reset;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_full        = (r_wr_ptr - r_rd_ptr) == BUF_DEPTH;
  assign w_lq_full     = (r_lq_wr - r_lq_rd) == LQ_DEPTH;
  assign w_lq_empty    = r_lq_wr == r_lq_rd;
  assign w_wr_en       = w_accept && !w_full && ({1'b0, r_wcnt} < MAX_L) && !r_ovf;
  assign w_wr_ptr_nxt  = r_wr_ptr + (w_wr_en ? PTR_ONE : '0);
  assign w_eof         = w_accept && s_axis_tlast;
  assign w_len         = {1'b0, r_wcnt} + 17'd1;

  assign w_drop_ovf = w_eof && (r_ovf || w_full || w_lq_full);
  assign w_drop_err = w_eof && !w_drop_ovf && s_axis_err;
  assign w_drop_len = w_eof && !w_drop_ovf && !s_axis_err && ((w_len < MIN_L) || (w_len > MAX_L));
  assign w_commit   = w_eof && !w_drop_ovf && !w_drop_err && !w_drop_len;

  // NOTE: storage arrays carry no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= s_axis_tdata;
    if (w_commit) r_lq_mem[r_lq_wr[LENQ_LOG2-1:0]] <= w_len[15:0];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_cmt_ptr <= '0;
      r_wcnt    <= '0;
      r_ovf     <= 1'b0;
      r_lq_wr   <= '0;
    end else if (w_eof) begin
      r_wcnt <= '0;
      r_ovf  <= 1'b0;
      if (w_commit) begin
        r_cmt_ptr <= w_wr_ptr_nxt;
        r_wr_ptr  <= w_wr_ptr_nxt;
        r_lq_wr   <= r_lq_wr + LQ_ONE;
      end else begin
        r_wr_ptr <= r_cmt_ptr;
      end
    end else if (w_accept) begin
      r_wr_ptr <= w_wr_ptr_nxt;
      if (r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
      if (w_full) r_ovf <= 1'b1;
    end
  end

  assign w_head    = r_lq_mem[r_lq_rd[LENQ_LOG2-1:0]];
  assign w_hs      = r_tvalid && m_axis_tready;
  assign w_last_hs = w_hs && (r_rcnt == 16'd1);
  // The output register is the RAM read port: fetch on the first beat and on each non-final handshake.
  assign w_fetch   = (r_state == S_SEND) && (!r_tvalid || (w_hs && !w_last_hs));
  assign w_rd_addr = r_rd_ptr[DEPTH_LOG2-1:0] + {{(DEPTH_LOG2-1){1'b0}}, w_hs};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_rcnt      <= '0;
      r_tuser_len <= '0;
      r_tvalid    <= 1'b0;
      r_lq_rd     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_lq_empty) begin
            r_rcnt      <= w_head;
            r_tuser_len <= w_head;
            r_state     <= S_SEND;
          end
        end
        default: begin
          if (!r_tvalid) begin
            r_tvalid <= 1'b1;
          end else if (w_hs) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_rcnt   <= r_rcnt - 16'd1;
            if (w_last_hs) begin
              r_tvalid <= 1'b0;
              r_lq_rd  <= r_lq_rd + LQ_ONE;
              r_state  <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        r_tdata <= '0;
    else if (w_fetch) r_tdata <= r_mem[w_rd_addr];
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tstrb  = r_tvalid;
  assign m_axis_tlast  = r_tvalid && (r_rcnt == 16'd1);
  assign m_axis_tuser  = {{(C_USER_WIDTH-16){1'b0}}, r_tuser_len};

`ifdef RX_FRAME_FILTER_STATS_EN
  logic [31:0] r_stat_good, r_stat_drop_err, r_stat_drop_len, r_stat_drop_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_good     <= '0;
      r_stat_drop_err <= '0;
      r_stat_drop_len <= '0;
      r_stat_drop_ovf <= '0;
    end else begin
      if (w_commit   && (r_stat_good     != 32'hFFFF_FFFF)) r_stat_good     <= r_stat_good + 32'd1;
      if (w_drop_err && (r_stat_drop_err != 32'hFFFF_FFFF)) r_stat_drop_err <= r_stat_drop_err + 32'd1;
      if (w_drop_len && (r_stat_drop_len != 32'hFFFF_FFFF)) r_stat_drop_len <= r_stat_drop_len + 32'd1;
      if (w_drop_ovf && (r_stat_drop_ovf != 32'hFFFF_FFFF)) r_stat_drop_ovf <= r_stat_drop_ovf + 32'd1;
    end
  end

  assign stat_good     = r_stat_good;
  assign stat_drop_err = r_stat_drop_err;
  assign stat_drop_len = r_stat_drop_len;
  assign stat_drop_ovf = r_stat_drop_ovf;
`else
  assign stat_good     = 32'd0;
  assign stat_drop_err = 32'd0;
  assign stat_drop_len = 32'd0;
  assign stat_drop_ovf = 32'd0;
`endif

endmodule

// File: tb/tb_rx_frame_filter.sv
// Directed bench for rx_frame_filter: known frames in, expected bytes/lengths queued by the bench,
// output beats compared against them; statistics expectations follow RX_FRAME_FILTER_STATS_EN.
module tb_rx_frame_filter;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    s_axis_tdata;
  logic          s_axis_tstrb;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          s_axis_err;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tstrb;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [31:0]   stat_good, stat_drop_err, stat_drop_len, stat_drop_ovf;

  always #5 clk = ~clk;

  rx_frame_filter dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_err(s_axis_err),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .stat_good(stat_good), .stat_drop_err(stat_drop_err), .stat_drop_len(stat_drop_len),
    .stat_drop_ovf(stat_drop_ovf)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  int         beat_idx = 0;
  int         cur_len = 0;
  int         rdy_mode = 1;
  int         rise_cyc = -100;
  int         last_in_cyc = 0;
  int         last_tl_cyc = 0;
  int         max_gap = 0;
  int         n_spurious = 0;
  bit         gap_en = 1'b0;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sx(input int n);
`ifdef RX_FRAME_FILTER_STATS_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_stats(input int g, input int e, input int l, input int o);
    check("stat_good",     stat_good,     sx(g));
    check("stat_drop_err", stat_drop_err, sx(e));
    check("stat_drop_len", stat_drop_len, sx(l));
    check("stat_drop_ovf", stat_drop_ovf, sx(o));
  endtask

  // Output side: drive tready, then judge the beat the next rising edge will take.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      if (m_axis_tvalid && !prev_valid) begin
        rise_cyc = cyc;
        if (gap_en && (cyc - last_tl_cyc - 1) > max_gap) max_gap = cyc - last_tl_cyc - 1;
      end
      prev_valid = m_axis_tvalid;
      if (!reset && m_axis_tvalid && m_axis_tready) begin
        if (exp_len.size() == 0) begin
          n_spurious++;
        end else begin
          cur_len = exp_len[0];
          check("tuser_len", 32'(m_axis_tuser[15:0]), 32'(cur_len));
          check("tdata", 32'(m_axis_tdata), 32'(exp_bytes.pop_front()));
          check("tlast", 32'(m_axis_tlast), 32'(beat_idx == cur_len - 1));
          check("tstrb", 32'(m_axis_tstrb), 32'd1);
          if (beat_idx == cur_len - 1) begin
            check("tuser_hi_zero", 32'(m_axis_tuser[UW-1:16] != '0), 32'd0);
            void'(exp_len.pop_front());
            beat_idx = 0;
            last_tl_cyc = cyc;
          end else begin
            beat_idx++;
          end
        end
      end
    end
  end

  task automatic send_frame(input int len, input bit err, input bit good, input logic [7:0] seed);
    if (good) begin
      exp_len.push_back(len);
      for (int i = 0; i < len; i++) exp_bytes.push_back(seed + 8'(i));
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = seed + 8'(i);
      s_axis_tlast  = (i == len - 1);
      s_axis_err    = (i == len - 1) ? err : 1'($urandom_range(0, 1));
      s_axis_tstrb  = 1'($urandom_range(0, 1));
      if (i == len - 1) last_in_cyc = cyc;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_err    = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_len.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_len.size()), 32'd0);
    exp_len.delete();
    exp_bytes.delete();
    beat_idx = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tstrb  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_err    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",    32'(m_axis_tdata),  32'd0);
    check("rst_tlast",    32'(m_axis_tlast),  32'd0);
    check("rst_tuser",    32'(m_axis_tuser[31:0]), 32'd0);
    check_stats(0, 0, 0, 0);
    reset = 1'b0;
    #1 check("s_tready_after_rst", 32'(s_axis_tready), 32'd1);

    // Minimum-length frame with the output free: contents, length and first-valid latency.
    rdy_mode = 1;
    send_frame(64, 1'b0, 1'b1, 8'h00);
    wait_drain("drain_64", 200);
    check("first_valid_latency", 32'(rise_cyc - last_in_cyc), 32'd3);
    check_stats(1, 0, 0, 0);

    // Runt and giant are dropped, a maximum-length frame passes.
    send_frame(63, 1'b0, 1'b0, 8'h10);
    send_frame(1519, 1'b0, 1'b0, 8'h20);
    check_stats(1, 0, 2, 0);
    send_frame(1518, 1'b0, 1'b1, 8'h30);
    wait_drain("drain_1518", 3000);
    check_stats(2, 0, 2, 0);

    // Error flag on tlast drops the frame; the following good frame is untouched.
    send_frame(100, 1'b1, 1'b0, 8'h40);
    send_frame(80, 1'b0, 1'b1, 8'h50);
    wait_drain("drain_80", 300);
    check_stats(3, 1, 2, 0);

    // Buffer overflow while the output is stalled; the stalled beat must hold.
    rdy_mode = 0;
    send_frame(1500, 1'b0, 1'b1, 8'h60);
    send_frame(1500, 1'b0, 1'b0, 8'h70);
    check_stats(4, 1, 2, 1);
    check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("stall_tdata",  32'(m_axis_tdata),  32'h60);
    check("stall_tuser",  32'(m_axis_tuser[15:0]), 32'd1500);
    rdy_mode = 1;
    wait_drain("drain_1500", 3000);

    // Length queue overflow: four frames queue up, the fifth is dropped; then inter-frame gap.
    rdy_mode = 0;
    for (int f = 0; f < 5; f++) send_frame(64, 1'b0, f < 4, 8'(8'h80 + f * 16));
    check_stats(8, 1, 2, 2);
    max_gap = 0;
    gap_en  = 1'b1;
    rdy_mode = 1;
    wait_drain("drain_lenq", 600);
    gap_en = 1'b0;
    check("max_gap_le_2", 32'(max_gap <= 2), 32'd1);

    // Random backpressure over 200 valid frames, input paced to keep at most two outstanding.
    rdy_mode = 2;
    for (int f = 0; f < 200; f++) begin
      int len;
      int n;
      len = $urandom_range(64, 128);
      n = 0;
      while (exp_len.size() >= 2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      send_frame(len, 1'b0, 1'b1, 8'($urandom));
    end
    wait_drain("drain_random", 2000);
    check_stats(208, 1, 2, 2);

    // Reset with a stalled frame on the output and a partial frame on the input.
    rdy_mode = 0;
    send_frame(64, 1'b0, 1'b1, 8'hA0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(i);
      s_axis_tlast  = 1'b0;
    end
    @(negedge clk);
    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("mid_rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    check("mid_rst_tdata",    32'(m_axis_tdata),  32'd0);
    check("mid_rst_tlast",    32'(m_axis_tlast),  32'd0);
    check("mid_rst_tuser",    32'(m_axis_tuser[31:0]), 32'd0);
    check_stats(0, 0, 0, 0);
    reset = 1'b0;
    exp_len.delete();
    exp_bytes.delete();
    beat_idx = 0;
    rdy_mode = 1;
    send_frame(64, 1'b0, 1'b1, 8'hC0);
    wait_drain("drain_post_reset", 200);
    check_stats(1, 0, 0, 0);
    check("spurious_beats", 32'(n_spurious), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_frame_filter.md
# rx_frame_filter

Single-clock store-and-forward frame filter on the 1G receive path, between the per-port `rx_queue` 8-bit AXI4-Stream master and the width converter that feeds the 64-bit datapath. It holds each frame in an internal byte buffer until its last byte arrives, then handles it as follows:
- Discards it if it is flagged bad, is shorter than the minimum length, is longer than the maximum length, or overflowed the buffer.
- Otherwise forwards it with its byte length in `m_axis_tuser[15:0]`, valid from the first beat.
- Optionally keeps per-cause statistics counters.

## Interface
Parameters:
- `DEPTH_LOG2`, 11: byte buffer depth is 2^DEPTH_LOG2 bytes.
- `LENQ_LOG2`, 2: length queue depth is 2^LENQ_LOG2 committed frames.
- `MIN_LEN`, 64: minimum accepted frame length in bytes, inclusive.
- `MAX_LEN`, 1518: maximum accepted frame length in bytes, inclusive.
- `C_USER_WIDTH`, 128: width of `m_axis_tuser`.

Ports:
- `clk` in 1: the single clock; all logic is synchronous to its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 8: receive byte.
- `s_axis_tstrb` in 1: ignored; every beat carries one byte.
- `s_axis_tvalid` in 1: input beat valid.
- `s_axis_tready` out 1: input beat accepted.
- `s_axis_tlast` in 1: last byte of the frame.
- `s_axis_err` in 1: bad-frame flag; sampled only on the tlast beat.
- `m_axis_tdata` out 8: output byte.
- `m_axis_tstrb` out 1: equals `m_axis_tvalid`.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: output beat accepted.
- `m_axis_tlast` out 1: last byte of the frame.
- `m_axis_tuser` out C_USER_WIDTH: bits [15:0] carry the frame length; all other bits are 0.
- `stat_good` out 32: count of frames forwarded.
- `stat_drop_err` out 32: count of frames dropped because `s_axis_err` was set.
- `stat_drop_len` out 32: count of frames dropped as runt or giant.
- `stat_drop_ovf` out 32: count of frames dropped because the buffer or length queue overflowed.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready` is 1 whenever `reset` is 0. The input is never stalled; congestion causes frame drops instead.

Write side:
- The write pointer `wr_ptr` and the commit pointer `cmt_ptr` are each DEPTH_LOG2+1 bits wide.
- The per-frame byte count `wcnt` is 16 bits wide and saturates at 0xFFFF.
- Each accepted byte increments `wcnt`.
- A byte is written to RAM at `wr_ptr`, and `wr_ptr` is incremented, only if all three conditions hold:
  - the buffer is not full (`wr_ptr - rd_ptr != 2^DEPTH_LOG2`);
  - `wcnt < MAX_LEN` before the increment;
  - the frame's `ovf` flag is clear.
- If a byte arrives when the buffer is full, the frame's `ovf` flag is set.

On the tlast beat, the length `L` is `wcnt + 1`. The frame's fate is decided by these rules, in priority order:
1. Drop for overflow if either of the following holds; increment `stat_drop_ovf`:
   - `ovf` is set, or the tlast byte itself hits a full buffer;
   - the length queue is full.
2. Otherwise, drop for error if `s_axis_err` is 1; increment `stat_drop_err`.
3. Otherwise, drop for length if `L < MIN_LEN` or `L > MAX_LEN`; increment `stat_drop_len`.
4. Otherwise, commit the frame:
   - set `cmt_ptr` to the post-write `wr_ptr`;
   - push `L` into the length queue;
   - increment `stat_good`.

A dropped frame sets `wr_ptr` back to `cmt_ptr`. In every case, `wcnt` and `ovf` clear for the next frame.

Read side, a two-state FSM:
- IDLE: if the length queue is non-empty, load the head length into `rcnt` and `m_axis_tuser[15:0]`, then go to SEND.
- SEND: bytes are read from `rd_ptr` through a 1-cycle-latency RAM into an output register.
  - `m_axis_tlast` is 1 when `rcnt == 1`.
  - On each handshake, `rd_ptr` increments and `rcnt` decrements.
  - On the tlast handshake, pop the length queue and return to IDLE.
- `m_axis_tuser` and `m_axis_tdata` hold steady while `m_axis_tvalid && !m_axis_tready`.

Simultaneous events:
- A commit (push) and a frame completion (pop) in the same cycle are both honoured.
- A drop that rewinds `wr_ptr` never affects read-side state.

## Timing
Reset values:
- all outputs are 0, except `s_axis_tready` (0 while `reset` is asserted, 1 in the first cycle after);
- the FSM is in IDLE;
- all pointers, counts and statistics are 0.

Reset mid-frame discards all buffered and partial frames. `m_axis_tvalid` is 0 in the cycle after `reset` is sampled high.

Latency and throughput, with the tlast input handshake at cycle T and an empty output side:
- commit is visible at T+1;
- the FSM enters SEND at T+2;
- the first `m_axis_tvalid` is at T+3;
- within a frame, one byte per cycle while `m_axis_tready` is 1;
- at most 2 idle cycles between the tlast beat of one frame and the first beat of the next queued frame.

The statistics counters saturate at 0xFFFFFFFF.

## Configuration
- The macro is `RX_FRAME_FILTER_STATS_EN`.
- Defined: the four `stat_*` counters are implemented as specified.
- Undefined: the counters are not built and all `stat_*` outputs are tied to 0. Filtering and forwarding behaviour is identical in both cases.

## Test plan
- 64-byte frame with incrementing data, `err` = 0, `m_axis_tready` held at 1 → bytes 0x00..0x3F out; `m_axis_tuser[15:0]` = 64; tlast on byte 64; first `m_axis_tvalid` at T+3; `stat_good` = 1.
- Frames of 63 and 1519 bytes → no output beats; `stat_drop_len` = 2; a following 1518-byte frame passes intact.
- 100-byte frame with `err` = 1 on tlast, then a good 80-byte frame → only the 80-byte frame is output; `stat_drop_err` = 1.
- `m_axis_tready` held at 0 while 1500-byte frames are sent back-to-back, with `DEPTH_LOG2` = 11 → frame 1 is committed; frame 2 overflows and is dropped (`stat_drop_ovf` increments); after `m_axis_tready` is released, frame 1 is output intact.
- Random `m_axis_tready` backpressure over 200 random valid frames → the output matches a reference model byte-for-byte, including lengths in `tuser`.
- `reset` asserted for 1 cycle mid-frame on both the input and output sides → all outputs and statistics are 0; the next 64-byte frame is forwarded correctly.
